// File: rtl/i2s_tx.sv
// I2S serial transmitter: follows an externally generated word clock, derives a
// phase-locked bit clock and shifts stereo samples out MSB-first with a one-bit delay.
module i2s_tx #(
  parameter int DIVCLK       = 256,
  parameter int BCLK_DIV     = 4,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                    mclkin,
  input  logic                    rst,
  input  logic                    word_clk,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int SLOTS = DIVCLK / (2 * BCLK_DIV);
  localparam int CW    = $clog2(BCLK_DIV);
  localparam int SLW   = $clog2(SLOTS);

  localparam logic [CW-1:0]  CNT_LAST  = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(BCLK_DIV / 2);
  localparam logic [SLW-1:0] SLOT_LAST = SLW'(SLOTS - 1);
  localparam logic [SLW-1:0] SLOT_DATA = SLW'(SAMPLE_WIDTH);

  logic                    wc_q, wc_d;
  logic                    active_q, active_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SLW-1:0]          slot_q, slot_d;
  logic [SAMPLE_WIDTH-1:0] sh_q, sh_d;
  logic [SAMPLE_WIDTH-1:0] frame_l_q, frame_l_d;
  logic [SAMPLE_WIDTH-1:0] frame_r_q, frame_r_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic                    full_q, full_d;
  logic                    started_q, started_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    underrun_q, underrun_d;

  logic edge_e, fall_e, rise_e, accept;

  assign edge_e = (word_clk != wc_q);
  assign fall_e = edge_e & ~word_clk;
  assign rise_e = edge_e & word_clk;
  assign s_ready = ~rst & ~full_q;
  assign accept  = s_valid & s_ready;

  always_comb begin
    wc_d       = word_clk;
    active_d   = active_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    sh_d       = sh_q;
    frame_l_d  = frame_l_q;
    frame_r_d  = frame_r_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    full_d     = full_q;
    started_d  = started_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;

    if (fall_e) begin
      active_d = 1'b1;
      lrclk_d  = 1'b0;
      cnt_d    = '0;
      slot_d   = '0;
      bclk_d   = 1'b0;
      sdata_d  = 1'b0;
      // Decision uses the pre-edge full flag; a pair accepted this cycle waits a frame.
      if (full_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
        full_d    = 1'b0;
      end else begin
        frame_l_d  = '0;
        frame_r_d  = '0;
        underrun_d = started_q;
      end
      sh_d = frame_l_d;
    end else if (active_q) begin
      lrclk_d = word_clk;
      if (rise_e) begin
        cnt_d   = '0;
        slot_d  = '0;
        bclk_d  = 1'b0;
        sdata_d = 1'b0;
        sh_d    = frame_r_q;
      end else begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Slot index saturates so over-long halves just keep sending zeros.
          if (slot_q != SLOT_LAST) slot_d = slot_q + 1'b1;
          if (slot_q < SLOT_DATA) begin
            sdata_d = sh_q[SAMPLE_WIDTH-1];
            sh_d    = sh_q << 1;
          end else begin
            sdata_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        bclk_d = (cnt_d >= CNT_HALF);
      end
    end

    if (accept) begin
      hold_l_d  = s_left;
      hold_r_d  = s_right;
      full_d    = 1'b1;
      started_d = 1'b1;
    end
  end

  always_ff @(posedge mclkin) begin
    // The word clock is tracked through reset so release never fakes an edge.
    wc_q <= wc_d;
    if (rst) begin
      active_q   <= 1'b0;
      cnt_q      <= '0;
      slot_q     <= '0;
      sh_q       <= '0;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      full_q     <= 1'b0;
      started_q  <= 1'b0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      sh_q       <= sh_d;
      frame_l_q  <= frame_l_d;
      frame_r_q  <= frame_r_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      full_q     <= full_d;
      started_q  <= started_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule
